// File: rtl/inst_pkg.sv
// Shared constants for the instruction-nibble encoder: class codes, opcodes, FSM states.
package inst_pkg;

  localparam logic [3:0] CLS_LD  = 4'd0;
  localparam logic [3:0] CLS_STR = 4'd1;
  localparam logic [3:0] CLS_SEI = 4'd2;
  localparam logic [3:0] CLS_SML = 4'd3;
  localparam logic [3:0] CLS_SMH = 4'd4;
  localparam logic [3:0] CLS_JMP = 4'd5;
  localparam logic [3:0] CLS_LDD = 4'd6;
  localparam logic [3:0] CLS_ARI = 4'd7;
  localparam logic [3:0] CLS_LOG = 4'd8;

  // Opcodes as I3..I0; JMP/ARI/LOG carry the sub-op in the low two bits.
  localparam logic [3:0] OPC_LD   = 4'b0000;
  localparam logic [3:0] OPC_STR  = 4'b0001;
  localparam logic [3:0] OPC_SEI  = 4'b0010;
  localparam logic [3:0] OPC_SML  = 4'b0011;
  localparam logic [3:0] OPC_SMH  = 4'b1111;
  localparam logic [3:0] OPC_LDD  = 4'b0111;
  localparam logic [1:0] OPC_JMP_HI = 2'b01;
  localparam logic [1:0] OPC_ARI_HI = 2'b10;
  localparam logic [1:0] OPC_LOG_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_GAPW = 2'd2,
    ST_ADR  = 2'd3
  } state_e;

endpackage

// File: rtl/inst_enc_map.sv
// Combinational class/sub-op to opcode map with operand and legality flags.
module inst_enc_map
  import inst_pkg::*;
(
  input  logic [3:0] cls_i,
  input  logic [1:0] sub_i,
  output logic [3:0] opcode_o,
  output logic       has_addr_o,
  output logic       illegal_o
);

  always_comb begin
    opcode_o   = 4'b0000;
    has_addr_o = 1'b0;
    illegal_o  = 1'b0;
    case (cls_i)
      CLS_LD:  opcode_o = OPC_LD;
      CLS_STR: opcode_o = OPC_STR;
      CLS_SEI: opcode_o = OPC_SEI;
      CLS_SML: opcode_o = OPC_SML;
      CLS_SMH: opcode_o = OPC_SMH;
      CLS_LDD: begin
        opcode_o   = OPC_LDD;
        has_addr_o = 1'b1;
      end
      CLS_JMP: begin
        opcode_o   = {OPC_JMP_HI, sub_i};
        has_addr_o = 1'b1;
        illegal_o  = (sub_i == 2'b11);
      end
      CLS_ARI: opcode_o = {OPC_ARI_HI, sub_i};
      CLS_LOG: begin
        opcode_o  = {OPC_LOG_HI, sub_i};
        illegal_o = (sub_i == 2'b11);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_enc.sv
// Instruction issuer: accepts a request, then strobes the opcode and LS-first
// address nibbles onto D, holding D for GAP idle cycles after each strobe.
module inst_enc
  import inst_pkg::*;
#(
  parameter int ADDR_NIB = 3,
  parameter int GAP      = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [3:0]            REQ_CLS,
  input  logic [1:0]            REQ_SUB,
  input  logic [4*ADDR_NIB-1:0] REQ_ADDR,
  output logic [3:0]            D,
  output logic                  STB,
  output logic                  BUSY,
  output logic                  ERR,
  output logic [1:0]            DBG_STATE
);

  // Handshake: a request transfers on a rising edge where REQ_VALID and
  // REQ_READY are both high; the requester holds fields stable until then.

  localparam logic [2:0] GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

  state_e                state_q;
  logic [3:0]            d_q;
  logic                  stb_q, busy_q, err_q;
  logic [2:0]            gap_cnt_q;
  logic [2:0]            rem_q;
  logic [4*ADDR_NIB-1:0] addr_q;

  logic [3:0] map_opc;
  logic       map_has_addr, map_illegal;
  logic       adv_d;

  inst_enc_map u_map (
    .cls_i      (REQ_CLS),
    .sub_i      (REQ_SUB),
    .opcode_o   (map_opc),
    .has_addr_o (map_has_addr),
    .illegal_o  (map_illegal)
  );

  // Time to emit the next nibble (or finish): right after a strobe when there
  // is no gap, otherwise at the end of the last gap cycle.
  always_comb begin
    adv_d = 1'b0;
    if (state_q == ST_OPC || state_q == ST_ADR) adv_d = (GAP == 0);
    else if (state_q == ST_GAPW)                 adv_d = (gap_cnt_q == GAP_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      d_q       <= 4'b0000;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      gap_cnt_q <= 3'd0;
      rem_q     <= 3'd0;
      addr_q    <= '0;
    end else begin
      stb_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ_VALID) begin
            if (map_illegal) begin
              err_q <= 1'b1;
            end else begin
              state_q <= ST_OPC;
              d_q     <= map_opc;
              stb_q   <= 1'b1;
              busy_q  <= 1'b1;
              addr_q  <= REQ_ADDR;
              rem_q   <= map_has_addr ? 3'(ADDR_NIB) : 3'd0;
            end
          end
        end
        default: begin
          if (adv_d) begin
            if (rem_q != 3'd0) begin
              state_q <= ST_ADR;
              d_q     <= addr_q[3:0];
              stb_q   <= 1'b1;
              addr_q  <= addr_q >> 4;
              rem_q   <= rem_q - 3'd1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (state_q == ST_GAPW) begin
            gap_cnt_q <= gap_cnt_q + 3'd1;
          end else begin
            state_q   <= ST_GAPW;
            gap_cnt_q <= 3'd0;
          end
        end
      endcase
    end
  end

  assign REQ_READY = (state_q == ST_IDLE) && !RST;
  assign D         = d_q;
  assign STB       = stb_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_inst_enc.sv
// Directed bench for inst_enc: one GAP=1 instance and one GAP=0 instance.
module tb_inst_enc;
  import inst_pkg::*;

  logic CLK, RST;
  int total = 0;
  int bad   = 0;

  logic        a_valid, a_ready, a_stb, a_busy, a_err;
  logic [3:0]  a_cls, a_d;
  logic [1:0]  a_sub, a_dbg;
  logic [11:0] a_addr;

  logic        b_valid, b_ready, b_stb, b_busy, b_err;
  logic [3:0]  b_cls, b_d;
  logic [1:0]  b_sub, b_dbg;
  logic [11:0] b_addr;

  logic [3:0] m_cls, m_opc;
  logic [1:0] m_sub;
  logic       m_has, m_ill;

  inst_enc #(.ADDR_NIB(3), .GAP(1)) u0 (
    .CLK(CLK), .RST(RST), .REQ_VALID(a_valid), .REQ_READY(a_ready),
    .REQ_CLS(a_cls), .REQ_SUB(a_sub), .REQ_ADDR(a_addr),
    .D(a_d), .STB(a_stb), .BUSY(a_busy), .ERR(a_err), .DBG_STATE(a_dbg)
  );

  inst_enc #(.ADDR_NIB(3), .GAP(0)) u1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(b_valid), .REQ_READY(b_ready),
    .REQ_CLS(b_cls), .REQ_SUB(b_sub), .REQ_ADDR(b_addr),
    .D(b_d), .STB(b_stb), .BUSY(b_busy), .ERR(b_err), .DBG_STATE(b_dbg)
  );

  inst_enc_map u_ref (
    .cls_i(m_cls), .sub_i(m_sub), .opcode_o(m_opc),
    .has_addr_o(m_has), .illegal_o(m_ill)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_d;
    logic       exp_stb;
    logic [1:0] sub;
    logic [11:0] addr;
    int nn;

    RST = 1'b1;
    a_valid = 0; a_cls = 0; a_sub = 0; a_addr = 0;
    b_valid = 0; b_cls = 0; b_sub = 0; b_addr = 0;
    m_cls = 0; m_sub = 0;

    // Reset state
    step(); step();
    check("rst_ready", a_ready, 0);
    check("rst_d", a_d, 4'b0000);
    check("rst_stb", a_stb, 0);
    check("rst_busy", a_busy, 0);
    check("rst_err", a_err, 0);
    check("rst_state", a_dbg, 2'd0);
    check("rst_ready_b", b_ready, 0);
    RST = 1'b0;
    step();
    check("ready_after_rst", a_ready, 1);
    check("ready_after_rst_b", b_ready, 1);

    // STR, GAP=1
    a_cls = CLS_STR; a_valid = 1;
    check("str_ready_t", a_ready, 1);
    step(); a_valid = 0;
    check("str_d", a_d, 4'b0001);
    check("str_stb1", a_stb, 1);
    check("str_busy1", a_busy, 1);
    check("str_ready1", a_ready, 0);
    check("str_err1", a_err, 0);
    step();
    check("str_stb2", a_stb, 0);
    check("str_busy2", a_busy, 1);
    check("str_d2", a_d, 4'b0001);
    check("str_ready2", a_ready, 0);
    step();
    check("str_ready3", a_ready, 1);
    check("str_busy3", a_busy, 0);
    check("str_err3", a_err, 0);

    // JMP sub=10, addr A5C, GAP=1
    a_cls = CLS_JMP; a_sub = 2'b10; a_addr = 12'hA5C; a_valid = 1;
    for (int c = 1; c <= 9; c++) begin
      step(); a_valid = 0;
      exp_stb = (c == 1 || c == 3 || c == 5 || c == 7);
      exp_d = (c < 3) ? 4'b0110 : (c < 5) ? 4'b1100 : (c < 7) ? 4'b0101 : 4'b1010;
      check($sformatf("jmp_stb_c%0d", c), a_stb, exp_stb);
      check($sformatf("jmp_d_c%0d", c), a_d, exp_d);
      check($sformatf("jmp_busy_c%0d", c), a_busy, (c <= 8));
      check($sformatf("jmp_ready_c%0d", c), a_ready, (c == 9));
      check($sformatf("jmp_err_c%0d", c), a_err, 0);
    end

    // LD accepted, then fields change while busy; SMH is what gets taken at READY
    a_cls = CLS_LD; a_sub = 0; a_valid = 1;
    step();
    check("hold_ld_d", a_d, 4'b0000);
    check("hold_ld_stb", a_stb, 1);
    a_cls = CLS_LDD; a_addr = 12'($urandom_range(0, 4095));
    step();
    check("hold_stb_gap", a_stb, 0);
    check("hold_ready_busy", a_ready, 0);
    a_cls = CLS_SMH;
    step();
    check("hold_ready_up", a_ready, 1);
    check("hold_stb_idle", a_stb, 0);
    step(); a_valid = 0;
    check("hold_smh_d", a_d, 4'b1111);
    check("hold_smh_stb", a_stb, 1);
    step();
    check("hold_smh_gap", a_stb, 0);
    step();
    check("hold_smh_ready", a_ready, 1);

    // Illegal: LOG sub=11 then class 12, back to back
    a_cls = CLS_LOG; a_sub = 2'b11; a_valid = 1;
    step();
    check("ill_log_err", a_err, 1);
    check("ill_log_stb", a_stb, 0);
    check("ill_log_d", a_d, 4'b1111);
    check("ill_log_ready", a_ready, 1);
    check("ill_log_busy", a_busy, 0);
    a_cls = 4'd12; a_sub = 2'b00;
    step(); a_valid = 0;
    check("ill_c12_err", a_err, 1);
    check("ill_c12_stb", a_stb, 0);
    check("ill_c12_d", a_d, 4'b1111);
    check("ill_c12_ready", a_ready, 1);
    step();
    check("ill_err_clear", a_err, 0);
    check("ill_stb_still0", a_stb, 0);

    // LDD aborted by reset in the cycle of the second strobe
    a_cls = CLS_LDD; a_addr = 12'h3B5; a_valid = 1;
    step(); a_valid = 0;
    check("ldd_opc", a_d, 4'b0111);
    check("ldd_stb1", a_stb, 1);
    step();
    check("ldd_gap", a_stb, 0);
    step();
    check("ldd_nib0", a_d, 4'b0101);
    check("ldd_stb2", a_stb, 1);
    RST = 1'b1;
    step();
    check("abort_stb", a_stb, 0);
    check("abort_d", a_d, 4'b0000);
    check("abort_busy", a_busy, 0);
    check("abort_err", a_err, 0);
    check("abort_ready_rst", a_ready, 0);
    RST = 1'b0;
    step();
    check("abort_ready", a_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort_no_stb_%0d", c), a_stb, 0);
      check($sformatf("abort_d_%0d", c), a_d, 4'b0000);
      step();
    end

    // GAP=0: ARI sub=01 then SMH back to back
    b_cls = CLS_ARI; b_sub = 2'b01; b_valid = 1;
    step();
    check("b2b_ari_d", b_d, 4'b1001);
    check("b2b_ari_stb", b_stb, 1);
    check("b2b_ari_ready", b_ready, 0);
    b_cls = CLS_SMH;
    step();
    check("b2b_stb_low", b_stb, 0);
    check("b2b_ready", b_ready, 1);
    check("b2b_busy_low", b_busy, 0);
    step(); b_valid = 0;
    check("b2b_smh_d", b_d, 4'b1111);
    check("b2b_smh_stb", b_stb, 1);
    step();
    check("b2b_end_stb", b_stb, 0);
    check("b2b_end_ready", b_ready, 1);

    // All legal classes on the GAP=0 instance against the reference map
    for (int k = 0; k <= 8; k++) begin
      if (k == 5 || k == 8) sub = 2'($urandom_range(0, 2));
      else sub = 2'($urandom_range(0, 3));
      addr = 12'($urandom_range(0, 4095));
      m_cls = 4'(k); m_sub = sub;
      b_cls = 4'(k); b_sub = sub; b_addr = addr; b_valid = 1;
      #1;
      check($sformatf("map_legal_%0d", k), m_ill, 0);
      check($sformatf("map_has_%0d", k), m_has, (k == 5 || k == 6));
      step(); b_valid = 0;
      check($sformatf("sweep_opc_%0d", k), b_d, m_opc);
      check($sformatf("sweep_stb_%0d", k), b_stb, 1);
      nn = (k == 5 || k == 6) ? 4 : 1;
      for (int j = 0; j < nn - 1; j++) begin
        step();
        check($sformatf("sweep_nstb_%0d_%0d", k, j), b_stb, 1);
        check($sformatf("sweep_nib_%0d_%0d", k, j), b_d, addr[4*j +: 4]);
      end
      step();
      check($sformatf("sweep_ready_%0d", k), b_ready, 1);
      check($sformatf("sweep_busy_%0d", k), b_busy, 0);
      check($sformatf("sweep_err_%0d", k), b_err, 0);
    end

    // Hand-checked opcodes for a few points of the map
    m_cls = CLS_LOG; m_sub = 2'b10; #1;
    check("map_log10", m_opc, 4'b1110);
    m_cls = CLS_ARI; m_sub = 2'b11; #1;
    check("map_ari11", m_opc, 4'b1011);
    m_cls = CLS_JMP; m_sub = 2'b11; #1;
    check("map_jmp11_ill", m_ill, 1);
    m_cls = 4'd9; m_sub = 2'b00; #1;
    check("map_c9_ill", m_ill, 1);
    m_cls = 4'd15; #1;
    check("map_c15_ill", m_ill, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
